instr_fetch: RTL and testbench

- Instruction fetch stage. Sits directly upstream of the decode/control unit and supplies the 32-bit `instr` word it decodes.
- Holds the program counter and issues word reads to instruction memory.
- Buffers returned words in a small prefetch FIFO.
- Presents one instruction at a time to decode with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all prefetched and in-flight words.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-limited imem reads, prefetch FIFO, redirect flush.
// Define INSTR_FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushed counters.
module instr_fetch #(
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_rd_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic [PC_W-1:0] fetch_pc
`ifdef INSTR_FETCH_PERF_CNT_EN
   ,output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_W-1:0] INC     = PC_W'(PC_INC);
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] resp_pc;
    logic [31:0]     data_q [DEPTH];
    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, outstanding, drop;
    logic [CW:0]     credit_used;
    logic            active, redir, empty, resp, dropping, push, pop, issue;

    assign active      = (state != IDLE);
    assign redir       = redirect & active;
    assign empty       = (count == '0);
    assign resp        = imem_rvalid & active & (outstanding != '0);
    assign dropping    = (drop != '0);
    assign push        = resp & ~dropping & ~redir;
    assign instr_valid = ~empty & ~redirect;
    assign pop         = instr_valid & instr_ready;
    // Words already buffered plus words still owed by memory must fit the FIFO.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign issue       = (state == RUN) & ~halt & ~redirect & (credit_used < CREDITS);

    assign imem_rd_en = issue;
    assign imem_addr  = issue ? pc : '0;
    assign instr      = empty ? '0 : data_q[rd_ptr];
    assign fetch_pc   = empty ? '0 : pc_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            unique case (state)
                IDLE:    state <= RUN;
                RUN:     if (!redir && halt) state <= HALTED;
                HALTED:  if (redir || !halt) state <= RUN;
                default: state <= IDLE;
            endcase

            if (redir)      pc <= redirect_pc;
            else if (issue) pc <= pc + INC;

            // Responses return in order, so the PC of the next kept word is implied.
            if (redir)     resp_pc <= redirect_pc;
            else if (push) resp_pc <= resp_pc + INC;

            if (issue && !resp)      outstanding <= outstanding + 1'b1;
            else if (!issue && resp) outstanding <= outstanding - 1'b1;

            if (redir)                 drop <= outstanding - CW'(resp);
            else if (resp && dropping) drop <= drop - 1'b1;

            if (redir) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef INSTR_FETCH_PERF_CNT_EN
    // Flushed = words cleared from the FIFO plus responses thrown away after a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_flushed <= perf_flushed + (redir ? 32'(count) : 32'd0)
                                         + 32'(resp & (dropping | redir));
        end
    end
`else
    // Counters not built; behaviour is otherwise identical.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random-latency in-order memory model plus a stream
// scoreboard (linear PC runs restarted at each redirect target).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] fetch_pc;

    logic        rd8;
    logic [7:0]  addr8;
    logic        rvalid8 = 1'b0;
    logic [31:0] rdata8 = '0;
    logic [31:0] instr8;
    logic        valid8;
    logic [7:0]  fpc8;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed, pf8, pfl8;
`endif

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset(reset), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .fetch_pc(fetch_pc)
`ifdef INSTR_FETCH_PERF_CNT_EN
       ,.perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    instr_fetch #(.PC_W(8), .RESET_PC(8'hFC)) w8 (
        .clk(clk), .reset(reset), .imem_rd_en(rd8), .imem_addr(addr8),
        .imem_rvalid(rvalid8), .imem_rdata(rdata8), .instr(instr8),
        .instr_valid(valid8), .instr_ready(1'b1), .redirect(1'b0),
        .redirect_pc(8'h00), .halt(1'b0), .fetch_pc(fpc8)
`ifdef INSTR_FETCH_PERF_CNT_EN
       ,.perf_fetched(pf8), .perf_flushed(pfl8)
`endif
    );

    // 8-bit instance: fixed 1-cycle memory returning a tagged copy of the address
    always @(posedge clk) begin
        rvalid8 <= reset ? 1'b0 : rd8;
        rdata8  <= {24'hABCDEF, addr8};
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    int total = 0, bad = 0;
    int cyc = 0, last_due = 0, mem_lat = 1;
    bit mem_rand = 1'b0;
    logic [31:0] exp_issue = '0, exp_pop = '0, last_pop = '1;
    int n_issued = 0, n_pop = 0;

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t mq[$];

    // Memory responder: in order, latency mem_lat (or random 1..3)
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            mq.delete();
            last_due    = 0;
            imem_rvalid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    end

    always @(negedge clk) begin
        int l, d;
        if (!reset && imem_rd_en) begin
            l = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            d = cyc + l;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: imem_addr, due: d});
        end
    end

    // Stream scoreboard: issue and delivery both follow linear PC runs
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_rd_en) begin
                total++;
                if (imem_addr !== exp_issue || halt) begin
                    bad++;
                    $display("FAIL sb_issue: addr %h halt %b, want addr %h halt 0", imem_addr, halt, exp_issue);
                end
                exp_issue = exp_issue + 32'd4;
                n_issued++;
            end
            if (redirect) begin
                total++;
                if (instr_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL sb_redirect_valid: got %b want 0", instr_valid);
                end
                exp_issue = redirect_pc;
                exp_pop   = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                total++;
                if (fetch_pc !== exp_pop || instr !== mem_word(exp_pop)) begin
                    bad++;
                    $display("FAIL sb_pop: pc %h instr %h, want pc %h instr %h", fetch_pc, instr, exp_pop, mem_word(exp_pop));
                end
                last_pop = fetch_pc;
                exp_pop  = exp_pop + 32'd4;
                n_pop++;
            end else if (!instr_valid) begin
                total++;
                if (instr !== 32'd0 || fetch_pc !== 32'd0) begin
                    bad++;
                    $display("FAIL sb_empty: instr %h pc %h, want 0 0", instr, fetch_pc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(posedge clk); #2;
        reset    = 1'b1;
        redirect = 1'b0;
        halt     = 1'b0;
        repeat (2) @(posedge clk);
        exp_issue = '0; exp_pop = '0; last_pop = '1; n_issued = 0; n_pop = 0;
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        mem_lat = 1; mem_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (imem_rd_en !== 1'b0 || imem_addr !== 32'd0 || rd8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_req: rd_en %b addr %h rd8 %b, want 0 0 0", imem_rd_en, imem_addr, rd8);
        end
        total++;
        if (instr !== 32'd0 || instr_valid !== 1'b0 || fetch_pc !== 32'd0) begin
            bad++;
            $display("FAIL reset_out: instr %h valid %b pc %h, want 0 0 0", instr, instr_valid, fetch_pc);
        end
`ifdef INSTR_FETCH_PERF_CNT_EN
        total++;
        if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf: fetched %0d flushed %0d, want 0 0", perf_fetched, perf_flushed);
        end
`endif
    endtask

    task automatic test_startup();
        logic [31:0] addrs[$];
        int first = -1;
        logic [31:0] fpc0 = '0, ins0 = '0;
        mem_lat = 1; mem_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (imem_rd_en) addrs.push_back(imem_addr);
            if (instr_valid && first < 0) begin
                first = k; fpc0 = fetch_pc; ins0 = instr;
            end
        end
        // release, then 3 rising edges (IDLE, request, response) -> valid at 4th negedge
        total++;
        if (first != 4) begin
            bad++;
            $display("FAIL startup_latency: first valid at negedge %0d, want 4", first);
        end
        total++;
        if (fpc0 !== 32'd0 || ins0 !== mem_word(32'd0)) begin
            bad++;
            $display("FAIL startup_word: pc %h instr %h, want 0 %h", fpc0, ins0, mem_word(32'd0));
        end
        total++;
        if (addrs.size() < 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            bad++;
            $display("FAIL startup_addrs: got %0d addrs first %h, want 0,4,8", addrs.size(), (addrs.size() > 0) ? addrs[0] : 32'hX);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] a[$];
        int got = 0;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd8) a.push_back(addr8);
            if (valid8 && got == 0) begin
                got = 1;
                total++;
                if (fpc8 !== 8'hFC || instr8 !== 32'hABCDEFFC) begin
                    bad++;
                    $display("FAIL wrap_word: pc %h instr %h, want fc abcdeffc", fpc8, instr8);
                end
            end
        end
        total++;
        if (a.size() < 3 || a[0] !== 8'hFC || a[1] !== 8'h00 || a[2] !== 8'h04) begin
            bad++;
            $display("FAIL wrap_addrs: count %0d, want fc,00,04", a.size());
        end
        total++;
        if (got != 1) begin
            bad++;
            $display("FAIL wrap_valid: no valid seen, want one");
        end
    endtask

    task automatic test_backpressure();
        int iss = 0;
        logic [31:0] pops[$];
        mem_lat = 1; mem_rand = 1'b0; instr_ready = 1'b0;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (imem_rd_en) iss++;
        end
        total++;
        if (iss != 4 || imem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL bp_credits: issued %0d rd_en %b, want 4 0", iss, imem_rd_en);
        end
        @(posedge clk); #2 instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) pops.push_back(fetch_pc);
        end
        total++;
        if (pops.size() < 4 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8 || pops[3] !== 32'hC) begin
            bad++;
            $display("FAIL bp_order: %0d pops first %h, want 0,4,8,c", pops.size(), (pops.size() > 0) ? pops[0] : 32'hX);
        end
    endtask

    task automatic test_redirect_drop();
        int iss = 0, seen = 0;
        mem_lat = 3; mem_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 10 && iss < 2; k++) begin
            @(negedge clk);
            if (imem_rd_en) iss++;
        end
        @(posedge clk); #2;
        redirect = 1'b1; redirect_pc = 32'h100;
        @(posedge clk); #2 redirect = 1'b0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1;
                total++;
                if (fetch_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
                    bad++;
                    $display("FAIL rd_drop_first: pc %h instr %h, want 100 %h", fetch_pc, instr, mem_word(32'h100));
                end
            end
        end
        total++;
        if (seen == 0 || iss != 2) begin
            bad++;
            $display("FAIL rd_drop_timeout: seen %0d issued %0d, want 1 2", seen, iss);
        end
`ifdef INSTR_FETCH_PERF_CNT_EN
        @(posedge clk); #1;
        total++;
        if (perf_flushed !== 32'd2 || perf_fetched !== 32'(n_pop)) begin
            bad++;
            $display("FAIL rd_drop_perf: flushed %0d fetched %0d, want 2 %0d", perf_flushed, perf_fetched, n_pop);
        end
`endif
    endtask

    task automatic test_redirect_pop();
        int seen = 0;
`ifdef INSTR_FETCH_PERF_CNT_EN
        logic [31:0] pf0;
`endif
        mem_lat = 1; mem_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        repeat (6) @(negedge clk);
        @(posedge clk); #2;
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL rp_pre_valid: got %b want 1", instr_valid);
        end
`ifdef INSTR_FETCH_PERF_CNT_EN
        pf0 = perf_fetched;
`endif
        redirect = 1'b1; redirect_pc = 32'h240;
        #1;
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL rp_valid: got %b want 0", instr_valid);
        end
        @(posedge clk); #1;
`ifdef INSTR_FETCH_PERF_CNT_EN
        total++;
        if (perf_fetched !== pf0) begin
            bad++;
            $display("FAIL rp_nopop: fetched %0d want %0d", perf_fetched, pf0);
        end
`endif
        #1 redirect = 1'b0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (instr_valid) seen = 1;
        end
        total++;
        if (seen == 0 || fetch_pc !== 32'h240 || instr !== mem_word(32'h240)) begin
            bad++;
            $display("FAIL rp_first: seen %0d pc %h, want 1 240", seen, fetch_pc);
        end
    endtask

    task automatic test_halt();
        int found = 0, iss = 0, after = 0;
        logic [31:0] a_after = '0;
        mem_lat = 1; mem_rand = 1'b0; instr_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (imem_rd_en && imem_addr == 32'h10) found = 1;
        end
        @(posedge clk); #2 halt = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (imem_rd_en) iss++;
        end
        total++;
        if (found == 0 || iss != 0 || last_pop !== 32'h10) begin
            bad++;
            $display("FAIL halt_hold: found %0d issued %0d last_pop %h, want 1 0 10", found, iss, last_pop);
        end
        @(posedge clk); #2 halt = 1'b0;
        for (int k = 0; k < 6 && after == 0; k++) begin
            @(negedge clk);
            if (imem_rd_en) begin after = 1; a_after = imem_addr; end
        end
        total++;
        if (after == 0 || a_after !== 32'h14) begin
            bad++;
            $display("FAIL halt_resume: seen %0d addr %h, want 1 14", after, a_after);
        end
    endtask

    task automatic test_random();
        mem_rand = 1'b1; instr_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) halt = ~halt;
            redirect = (i > 3) && ($urandom_range(0, 29) == 0);
            if (redirect) redirect_pc = $urandom & 32'hFFFF_FFFC;
        end
        @(posedge clk); #2;
        redirect = 1'b0; halt = 1'b1; instr_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (instr_valid !== 1'b0 || mq.size() != 0 || n_pop == 0) begin
            bad++;
            $display("FAIL rand_drain: valid %b pending %0d pops %0d, want 0 0 >0", instr_valid, mq.size(), n_pop);
        end
`ifdef INSTR_FETCH_PERF_CNT_EN
        total++;
        if (perf_fetched !== 32'(n_pop) || perf_flushed !== 32'(n_issued - n_pop)) begin
            bad++;
            $display("FAIL rand_perf: fetched %0d flushed %0d, want %0d %0d", perf_fetched, perf_flushed, n_pop, n_issued - n_pop);
        end
`endif
        halt = 1'b0; mem_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_wrap();
        test_backpressure();
        test_redirect_drop();
        test_redirect_pop();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
